rf_writeback: RTL and testbench
===============================

# rf_writeback

Write-port driver for the 32×64-bit register file. It is the producer side of the file's wen/rD/din/ppp write interface. It accepts single-cycle ALU results and variable-latency load returns, buffers the loads, and arbitrates between the two sources. It drives exactly one registered write per cycle and keeps a per-register scoreboard of outstanding loads, which the issue stage uses to stall.

## Interface
Parameters:
- FIFO_DEPTH, 2, load-return buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive load grants allowed while an ALU result waits

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high
- alu_rd  in  5  destination register
- alu_ppp  in  3  partial-write select
- alu_data  in  64  result, bit [0] = MSB
- ld_valid  in  1  load return offered
- ld_ready  out  1  load FIFO can accept
- ld_rd  in  5  load destination register
- ld_ppp  in  3  load partial-write select
- ld_data  in  64  load data
- iss_valid  in  1  a load is being issued this cycle
- iss_rd  in  5  issued load's destination
- rf_wen  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_din  out  64  register-file write data
- rf_ppp  out  3  register-file partial-write select
- busy  out  32  bit i = load pending to register i (bit 0 always 0)
- ppp_err  out  1  one-cycle pulse when an accepted write carries ppp 101–111

## Operation
- ppp encoding:
  - 000 = full 64 bits
  - 001 = bits [0:31]
  - 010 = bits [32:63]
  - 011 = even bytes, bits [0:7],[16:23],[32:39],[48:55]
  - 100 = odd bytes, bits [8:15],[24:31],[40:47],[56:63]
  - 101–111 = invalid
- Loads always enter the FIFO; they are never bypassed. ld_ready = FIFO count < FIFO_DEPTH, computed from registered count.
- Grant, evaluated each cycle:
  - FIFO non-empty and starve_cnt < STARVE_LIMIT → dequeue head, drive it to the output.
  - Otherwise → alu_ready = 1; if alu_valid is high, drive the ALU result.
  - alu_ready is 1 exactly when the FIFO is empty or starve_cnt == STARVE_LIMIT.
- starve_cnt:
  - Increments on each load grant while alu_valid is high.
  - Clears on any ALU grant, or on any cycle with alu_valid low.
  - Saturates at STARVE_LIMIT.
- Write suppression: a granted write with rd == 0 or invalid ppp completes its handshake but drives rf_wen = 0. Invalid ppp also pulses ppp_err. rf_rd/rf_din/rf_ppp still update.
- Scoreboard:
  - iss_valid sets busy[iss_rd].
  - A granted load write (including suppressed ones) clears busy[rd].
  - Same register set and cleared in the same cycle → set wins.
  - iss_rd == 0 is ignored.
- Simultaneous ld_valid and alu_valid with an empty FIFO: the load is enqueued and the ALU result is granted in the same cycle.

## Timing
- Reset values: rf_wen 0, rf_rd 0, rf_din 0, rf_ppp 000, busy all 0, ppp_err 0, FIFO empty, starve_cnt 0. After reset, ld_ready = 1 and alu_ready = 1.
- ALU latency: accepted in cycle N → rf_wen/fields valid in cycle N+1, held for exactly one cycle.
- Load latency: accepted in cycle N → earliest write in cycle N+2.
- busy updates one cycle after iss_valid. busy clears in the same cycle the load's rf_wen is asserted.
- Reset mid-operation: FIFO contents are discarded, the scoreboard is cleared, and no write occurs in the cycle after reset.
- FIFO full plus simultaneous dequeue: ld_ready stays 0 that cycle (registered count), and rises the next cycle.

## Structure
- Shared package rf_pkg holds:
  - RF_ADDR_W = 5, RF_DATA_W = 64
  - PPP_FULL, PPP_HI, PPP_LO, PPP_EVEN, PPP_ODD localparams
  - packed wb_req_t {rd, ppp, data}
  - function ppp_valid()
- One sub-module, wb_fifo: synchronous FIFO of wb_req_t, parameterised by FIFO_DEPTH, exposing count, full, empty, push, pop, head. Wrap-around uses pointers one bit wider than the address.

## Test plan
- Reset, then ALU rd=5, ppp=000, data=64'h0123_4567_89AB_CDEF → next cycle rf_wen=1, rf_rd=5, rf_din equal to the data; following cycle rf_wen=0.
- iss_rd=7, then 3 cycles later a load return rd=7, ppp=011 → busy[7]=1 from the cycle after issue; write appears 2 cycles after load acceptance with rf_ppp=011; busy[7] clears in that same cycle.
- Load FIFO full, alu_valid held high, loads arriving every cycle → at most 4 consecutive load writes, then one ALU write; ld_ready=0 while count=2.
- ALU rd=0 with ppp=000, and ALU rd=3 with ppp=110 → both accepted, rf_wen=0 each time, ppp_err pulses only for the ppp=110 write.
- iss_valid rd=9 in the same cycle a load write to rd=9 is granted → busy[9] remains 1.
- Reset asserted with 2 loads queued and busy=0x0000_0300 → all outputs 0 next cycle, and no queued load is ever written.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write path.
// Data words are numbered MSB-first: bit [0] is the most significant bit.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 64;
  localparam int RF_PPP_W  = 3;
  localparam int RF_NREGS  = 1 << RF_ADDR_W;

  localparam logic [RF_PPP_W-1:0] PPP_FULL = 3'b000;
  localparam logic [RF_PPP_W-1:0] PPP_HI   = 3'b001;
  localparam logic [RF_PPP_W-1:0] PPP_LO   = 3'b010;
  localparam logic [RF_PPP_W-1:0] PPP_EVEN = 3'b011;
  localparam logic [RF_PPP_W-1:0] PPP_ODD  = 3'b100;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_PPP_W-1:0]  ppp;
    logic [0:RF_DATA_W-1] data;
  } wb_req_t;

  function automatic logic ppp_valid(input logic [RF_PPP_W-1:0] ppp);
    case (ppp)
      PPP_FULL, PPP_HI, PPP_LO, PPP_EVEN, PPP_ODD: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rf_writeback_wb_fifo.sv
// Synchronous FIFO of write requests. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter register.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  wb_req_t                din,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  wb_req_t     r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign head  = r_mem[r_rd_ptr[AW-1:0]];
  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port driver: arbitrates ALU results against buffered
// load returns, issues one registered write per cycle, tracks pending loads.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [RF_ADDR_W-1:0] alu_rd,
  input  logic [RF_PPP_W-1:0]  alu_ppp,
  input  logic [0:RF_DATA_W-1] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [RF_ADDR_W-1:0] ld_rd,
  input  logic [RF_PPP_W-1:0]  ld_ppp,
  input  logic [0:RF_DATA_W-1] ld_data,
  input  logic                 iss_valid,
  input  logic [RF_ADDR_W-1:0] iss_rd,
  output logic                 rf_wen,
  output logic [RF_ADDR_W-1:0] rf_rd,
  output logic [0:RF_DATA_W-1] rf_din,
  output logic [RF_PPP_W-1:0]  rf_ppp,
  output logic [RF_NREGS-1:0]  busy,
  output logic                 ppp_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] SW_ONE  = 1;

  wb_req_t              w_enq;
  wb_req_t              w_head;
  wb_req_t              w_alu_req;
  wb_req_t              w_sel;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_ld_grant;
  logic                 w_alu_grant;
  logic                 w_grant;
  logic                 w_sel_ppp_ok;
  logic [SW-1:0]        w_starve_next;
  logic [RF_NREGS-1:0]  w_busy_next;

  logic [SW-1:0]        r_starve_cnt;
  logic                 r_wen;
  logic [RF_ADDR_W-1:0] r_rd;
  logic [0:RF_DATA_W-1] r_din;
  logic [RF_PPP_W-1:0]  r_ppp;
  logic                 r_err;
  logic [RF_NREGS-1:0]  r_busy;

  assign w_enq     = {ld_rd, ld_ppp, ld_data};
  assign w_alu_req = {alu_rd, alu_ppp, alu_data};

  // ld_ready comes from the registered count, so a full FIFO being drained
  // this cycle still refuses a new return until the next cycle.
  assign ld_ready = (w_count < DEPTH_C);
  assign w_push   = ld_valid && !w_full;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_ld_grant),
    .din   (w_enq),
    .head  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_ld_grant   = !w_empty && (r_starve_cnt < LIMIT_C);
  assign alu_ready    = !w_ld_grant;
  assign w_alu_grant  = alu_ready && alu_valid;
  assign w_grant      = w_ld_grant || w_alu_grant;
  assign w_sel        = w_ld_grant ? w_head : w_alu_req;
  assign w_sel_ppp_ok = ppp_valid(w_sel.ppp);

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (!alu_valid || w_alu_grant) begin
      w_starve_next = '0;
    end else if (w_ld_grant && (r_starve_cnt != LIMIT_C)) begin
      w_starve_next = r_starve_cnt + SW_ONE;
    end
  end

  // Clear first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_ld_grant) w_busy_next[w_head.rd] = 1'b0;
    if (iss_valid)  w_busy_next[iss_rd]    = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_wen        <= 1'b0;
      r_rd         <= '0;
      r_din        <= '0;
      r_ppp        <= PPP_FULL;
      r_err        <= 1'b0;
      r_busy       <= '0;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_busy       <= w_busy_next;
      r_wen        <= w_grant && (w_sel.rd != '0) && w_sel_ppp_ok;
      r_err        <= w_grant && !w_sel_ppp_ok;
      if (w_grant) begin
        r_rd  <= w_sel.rd;
        r_din <= w_sel.data;
        r_ppp <= w_sel.ppp;
      end
    end
  end

  assign rf_wen  = r_wen;
  assign rf_rd   = r_rd;
  assign rf_din  = r_din;
  assign rf_ppp  = r_ppp;
  assign ppp_err = r_err;
  assign busy    = r_busy;

endmodule

// File: tb/tb_rf_writeback.sv
// Randomized scoreboard bench for rf_writeback: a queue-based reference model
// predicts each visible write; a negedge monitor pops and compares.
module tb_rf_writeback;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [2:0]  alu_ppp = '0;
  logic [63:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [2:0]  ld_ppp = '0;
  logic [63:0] ld_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_din;
  logic [2:0]  rf_ppp;
  logic [31:0] busy;
  logic        ppp_err;

  always #5 clk = ~clk;

  rf_writeback #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_ppp   (alu_ppp),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_ppp    (ld_ppp),
    .ld_data   (ld_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_din    (rf_din),
    .rf_ppp    (rf_ppp),
    .busy      (busy),
    .ppp_err   (ppp_err)
  );

  typedef struct {
    int        cyc;
    bit        wen;
    bit        err;
    bit [4:0]  rd;
    bit [2:0]  ppp;
    bit [63:0] data;
  } exp_t;

  typedef struct {
    bit [4:0]  rd;
    bit [2:0]  ppp;
    bit [63:0] data;
  } req_t;

  typedef struct {
    bit        av;
    bit [4:0]  ard;
    bit [2:0]  appp;
    bit [63:0] adata;
    bit        lv;
    bit [4:0]  lrd;
    bit [2:0]  lppp;
    bit [63:0] ldata;
    bit        iv;
    bit [4:0]  ird;
  } stim_t;

  exp_t      exp_q[$];
  req_t      m_fifo[$];
  int        m_starve = 0;
  bit [31:0] m_busy = '0;
  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: check state-derived outputs, drive inputs, advance model.
  task automatic step(input stim_t s);
    bit   exp_ldr;
    bit   exp_alur;
    bit   ld_grant;
    bit   have;
    req_t g;
    exp_t e;
    @(posedge clk);
    #1;
    check("busy", busy, m_busy);
    exp_ldr  = (m_fifo.size() < DEPTH);
    exp_alur = (m_fifo.size() == 0) || (m_starve == LIMIT);
    ld_grant = (m_fifo.size() > 0) && (m_starve < LIMIT);
    check("ld_ready", ld_ready, exp_ldr);
    check("alu_ready", alu_ready, exp_alur);

    alu_valid = s.av; alu_rd = s.ard; alu_ppp = s.appp; alu_data = s.adata;
    ld_valid = s.lv;  ld_rd = s.lrd;  ld_ppp = s.lppp;  ld_data = s.ldata;
    iss_valid = s.iv; iss_rd = s.ird;

    have = 1'b0;
    if (ld_grant) begin
      g = m_fifo.pop_front();
      have = 1'b1;
      m_busy[g.rd] = 1'b0;
    end else if (s.av) begin
      g = '{rd: s.ard, ppp: s.appp, data: s.adata};
      have = 1'b1;
    end
    if (have) begin
      e.cyc  = cyc + 1;
      e.wen  = (g.rd != 0) && (g.ppp <= 3'd4);
      e.err  = (g.ppp > 3'd4);
      e.rd   = g.rd;
      e.ppp  = g.ppp;
      e.data = g.data;
      if (e.wen || e.err) exp_q.push_back(e);
    end
    if (s.iv && s.ird != 0) m_busy[s.ird] = 1'b1;
    if (!s.av) m_starve = 0;
    else if (ld_grant) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    else m_starve = 0;
    if (s.lv && exp_ldr) m_fifo.push_back('{rd: s.lrd, ppp: s.lppp, data: s.ldata});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
    m_fifo.delete();
    m_starve = 0;
    m_busy = '0;
    @(posedge clk);
    #1;
    check("rst_rf_wen", rf_wen, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_rf_din", rf_din, 0);
    check("rst_rf_ppp", rf_ppp, 0);
    check("rst_busy", busy, 0);
    check("rst_ppp_err", ppp_err, 0);
    reset = 1'b0;
  endtask

  // Monitor: every visible write must match the oldest prediction, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write: got none want rd=%0d ppp=%0d at cyc %0d", e.rd, e.ppp, e.cyc);
      end
      if (rf_wen === 1'b1 || ppp_err === 1'b1) begin
        $display("wb cyc=%0d wen=%b err=%b rd=%0d ppp=%0d din=%h", cyc, rf_wen, ppp_err, rf_rd, rf_ppp, rf_din);
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          check("wr_wen", rf_wen, e.wen);
          check("wr_err", ppp_err, e.err);
          check("wr_rd", rf_rd, e.rd);
          check("wr_ppp", rf_ppp, e.ppp);
          check("wr_data", rf_din, e.data);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got rd=%0d wen=%b err=%b want no write at cyc %0d", rf_rd, rf_wen, ppp_err, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    stim_t idle;
    idle = '{default: '0};
    do_reset();

    s = idle; s.av = 1; s.ard = 5; s.appp = 3'b000; s.adata = 64'h0123_4567_89AB_CDEF;
    step(s);
    step(idle); step(idle);

    s = idle; s.iv = 1; s.ird = 7;
    step(s);
    step(idle); step(idle);
    s = idle; s.lv = 1; s.lrd = 7; s.lppp = 3'b011; s.ldata = 64'hDEAD_BEEF_0BAD_F00D;
    step(s);
    step(idle); step(idle); step(idle);

    s = idle; s.av = 1; s.ard = 0; s.appp = 3'b000; s.adata = 64'h1111;
    step(s);
    s = idle; s.av = 1; s.ard = 3; s.appp = 3'b110; s.adata = 64'h2222;
    step(s);
    step(idle); step(idle);

    s = idle; s.iv = 1; s.ird = 9;
    step(s);
    s = idle; s.lv = 1; s.lrd = 9; s.lppp = 3'b001; s.ldata = 64'h9999;
    step(s);
    s = idle; s.iv = 1; s.ird = 9;
    step(s);
    step(idle); step(idle);

    for (int i = 0; i < 14; i++) begin
      s = idle;
      s.av = 1; s.ard = 5'(i + 1); s.appp = 3'b000; s.adata = 64'(32'hA000 + i);
      s.lv = 1; s.lrd = 5'(i + 10); s.lppp = 3'b010; s.ldata = 64'(32'hB000 + i);
      step(s);
    end
    for (int i = 0; i < 4; i++) step(idle);

    for (int i = 0; i < 6; i++) begin
      s = idle;
      s.av = 1; s.ard = 2; s.adata = 64'(32'hC000 + i);
      s.lv = 1; s.lrd = 5'(20 + i); s.ldata = 64'(32'hD000 + i);
      s.iv = (i < 2); s.ird = 5'(8 + i);
      step(s);
    end
    do_reset();
    for (int i = 0; i < 4; i++) step(idle);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      s.av    = ($urandom_range(0, 3) != 0);
      s.ard   = 5'($urandom);
      s.appp  = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      s.adata = {$urandom, $urandom};
      s.lv    = ($urandom_range(0, 1) == 1);
      s.lrd   = 5'($urandom);
      s.lppp  = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      s.ldata = {$urandom, $urandom};
      s.iv    = ($urandom_range(0, 2) == 0);
      s.ird   = 5'($urandom);
      step(s);
    end
    for (int i = 0; i < 8; i++) step(idle);
    @(negedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
